// File: rtl/adc_align_pkg.sv
// Shared types and default constants for the ADC bitslip alignment block.
package adc_align_pkg;

  // Alignment sequencer states.
  typedef enum logic [2:0] {
    WAIT_RST = 3'd0,
    SETTLE   = 3'd1,
    CHECK    = 3'd2,
    SLIP     = 3'd3,
    LOCKED   = 3'd4,
    FAIL     = 3'd5
  } align_state_e;

  // Default parameter values for the top level.
  localparam int         DEF_DATA_W        = 8;
  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hF0;
  localparam int         DEF_SETTLE_CYC    = 4;
  localparam int         DEF_MATCH_CNT     = 16;

endpackage

// File: rtl/my_sync.sv
// Two-flop synchronizer for a single level signal. Reset preloads both
// stages to 1 so a synchronized reset request is held until the real
// input has been seen low for two clocks.
module my_sync (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Shift the asynchronous input through two stages.
  always_comb begin
    meta_d = in;
    sync_d = meta_q;
  end

  // Synchronizer flops, preset to 1 on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign out = sync_q;

endmodule

// File: rtl/adc_bitslip_align.sv
// ISERDES word alignment: after the SelectIO reset releases, compare the
// deserialized word against the ADC training pattern and issue bitslip
// strobes until the pattern is seen MATCH_CNT times in a row, or every
// bit phase has been tried.
module adc_bitslip_align
  import adc_align_pkg::*;
#(
  parameter int                DATA_W        = DEF_DATA_W,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(DEF_TRAIN_PATTERN),
  parameter int                SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter int                MATCH_CNT     = DEF_MATCH_CNT
) (
  input  logic                      clk_adc,
  input  logic                      rst_adc,
  input  logic                      sel_io_rst,
  input  logic                      realign,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      bitslip,
  output logic                      aligned,
  output logic                      align_err,
  output logic [$clog2(DATA_W):0]   slip_cnt
);

  localparam int SLIP_W = $clog2(DATA_W) + 1;
  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int MCH_W  = $clog2(MATCH_CNT + 1);

  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [MCH_W-1:0]  MATCH_LAST  = MCH_W'(MATCH_CNT - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(DATA_W - 1);

  logic io_rst_s;

  align_state_e      state_q,     state_d;
  logic [SET_W-1:0]  settle_q,    settle_d;
  logic [MCH_W-1:0]  match_q,     match_d;
  logic [SLIP_W-1:0] slip_cnt_q,  slip_cnt_d;
  logic              bitslip_q,   bitslip_d;
  logic              aligned_q,   aligned_d;
  logic              align_err_q, align_err_d;

  // The SelectIO reset is the only asynchronous input; nothing else looks at it raw.
  my_sync u_io_rst_sync (
    .clk (clk_adc),
    .rst (rst_adc),
    .in  (sel_io_rst),
    .out (io_rst_s)
  );

  // Next-state and counter logic; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    match_d    = match_q;
    slip_cnt_d = slip_cnt_q;

    if (io_rst_s) begin
      state_d    = WAIT_RST;
      settle_d   = '0;
      match_d    = '0;
      slip_cnt_d = '0;
    end else begin
      case (state_q)
        WAIT_RST: begin
          state_d    = SETTLE;
          settle_d   = SETTLE_LOAD;
          match_d    = '0;
          slip_cnt_d = '0;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_d = CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        CHECK: begin
          if (data_in == TRAIN_PATTERN) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            if (slip_cnt_q == SLIP_MAX) begin
              state_d = FAIL;
            end else begin
              state_d = SLIP;
            end
          end
        end
        SLIP: begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
          if (slip_cnt_q != SLIP_MAX) begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
        end
        LOCKED, FAIL: begin
          if (realign) begin
            state_d    = SETTLE;
            settle_d   = SETTLE_LOAD;
            match_d    = '0;
            slip_cnt_d = '0;
          end
        end
        default: begin
          state_d = WAIT_RST;
        end
      endcase
    end

    bitslip_d   = (state_d == SLIP);
    aligned_d   = (state_d == LOCKED);
    align_err_d = (state_d == FAIL);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      state_q     <= WAIT_RST;
      settle_q    <= '0;
      match_q     <= '0;
      slip_cnt_q  <= '0;
      bitslip_q   <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      match_q     <= match_d;
      slip_cnt_q  <= slip_cnt_d;
      bitslip_q   <= bitslip_d;
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
    end
  end

  assign bitslip   = bitslip_q;
  assign aligned   = aligned_q;
  assign align_err = align_err_q;
  assign slip_cnt  = slip_cnt_q;

endmodule

// File: tb/tb_adc_bitslip_align.sv
// Directed bench for adc_bitslip_align with a simple ISERDES model that
// rotates the ADC word left by one bit for every bitslip strobe.
module tb_adc_bitslip_align;

   logic       clk_adc = 1'b0;
   logic       rst_adc;
   logic       sel_io_rst;
   logic       realign;
   logic [7:0] data_in;
   logic       bitslip;
   logic       aligned;
   logic       align_err;
   logic [3:0] slip_cnt;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0] baseWord   = 8'hF0;
   logic       randomMode = 1'b0;
   int         slipOffset = 0;
   int         pulseStart = 0;

   logic [7:0] randWord     = 8'h00;
   int         modelSlips   = 0;
   int         pulseCount   = 0;
   int         widePulses   = 0;
   int         minSpacing   = 1000;
   int         lastPulseCyc = -1;
   int         cycleCount   = 0;
   logic       prevBitslip  = 1'b0;

   adc_bitslip_align dut (
      .clk_adc    (clk_adc),
      .rst_adc    (rst_adc),
      .sel_io_rst (sel_io_rst),
      .realign    (realign),
      .data_in    (data_in),
      .bitslip    (bitslip),
      .aligned    (aligned),
      .align_err  (align_err),
      .slip_cnt   (slip_cnt)
   );

   // 100 MHz-style free-running clock
   always #5 clk_adc = ~clk_adc;

   function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
      logic [7:0] r;
      r = w;
      for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] pickRand();
      logic [7:0] r;
      r = 8'($urandom);
      if (r == 8'hF0) r = 8'h0F;
      return r;
   endfunction

   // ISERDES word as seen after the slips issued since the current phase began
   assign data_in = randomMode ? randWord : rotl(baseWord, modelSlips - slipOffset);

   // ISERDES model plus a bitslip monitor tracking pulse count, width and spacing
   always @(posedge clk_adc) begin
      cycleCount  <= cycleCount + 1;
      randWord    <= pickRand();
      prevBitslip <= bitslip;
      if (bitslip) begin
         modelSlips <= modelSlips + 1;
         pulseCount <= pulseCount + 1;
         if (prevBitslip) widePulses <= widePulses + 1;
         if (lastPulseCyc >= 0 && (cycleCount - lastPulseCyc) < minSpacing)
            minSpacing <= cycleCount - lastPulseCyc;
         lastPulseCyc <= cycleCount;
      end
   end

   // Advance n clocks, landing just after the active edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk_adc);
      #1;
   endtask

   task automatic applyStimulus(input logic rstV, input logic ioRstV, input logic realignV);
      rst_adc    = rstV;
      sel_io_rst = ioRstV;
      realign    = realignV;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Wait with a cycle budget for the sequencer to reach lock or failure
   task automatic waitForDone(input string tag, input int maxCyc);
      int n;
      n = 0;
      while (!(aligned || align_err) && n < maxCyc) begin
         tick(1);
         n++;
      end
      checkOutput(tag, 32'(aligned || align_err), 32'd1);
   endtask

   // Start a new phase: model data rebased, SelectIO reset released
   task automatic releaseIo(input logic [7:0] word);
      baseWord   = word;
      slipOffset = modelSlips;
      pulseStart = pulseCount;
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(3);
      checkOutput("rst_bitslip",   32'(bitslip),   32'd0);
      checkOutput("rst_aligned",   32'(aligned),   32'd0);
      checkOutput("rst_align_err", 32'(align_err), 32'd0);
      checkOutput("rst_slip_cnt",  32'(slip_cnt),  32'd0);

      // Reset released but SelectIO reset still held: must stay idle
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(30);
      checkOutput("hold_aligned", 32'(aligned), 32'd0);
      checkOutput("hold_pulses",  32'(pulseCount), 32'd0);

      // Phase 0: lock exactly 2+1+4+16 clocks after release, no slips
      $display("[TB] phase 0 alignment");
      releaseIo(8'hF0);
      tick(22);
      checkOutput("p0_not_yet", 32'(aligned), 32'd0);
      tick(1);
      checkOutput("p0_lock",     32'(aligned),  32'd1);
      checkOutput("p0_slip_cnt", 32'(slip_cnt), 32'd0);
      checkOutput("p0_pulses",   32'(pulseCount - pulseStart), 32'd0);

      // SelectIO reset while locked: back to idle within 3 clocks
      pulseStart = pulseCount;
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(2);
      checkOutput("lk_io_rst_2cyc", 32'(aligned), 32'd1);
      tick(1);
      checkOutput("lk_io_rst_aligned",  32'(aligned),  32'd0);
      checkOutput("lk_io_rst_slip_cnt", 32'(slip_cnt), 32'd0);
      checkOutput("lk_io_rst_pulses",   32'(pulseCount - pulseStart), 32'd0);

      // Phase 3 offset: three slips then lock
      $display("[TB] phase 3 alignment");
      releaseIo(8'h1E);
      waitForDone("p3_done", 300);
      checkOutput("p3_aligned",   32'(aligned),   32'd1);
      checkOutput("p3_align_err", 32'(align_err), 32'd0);
      checkOutput("p3_slip_cnt",  32'(slip_cnt),  32'd3);
      checkOutput("p3_pulses",    32'(pulseCount - pulseStart), 32'd3);
      checkOutput("p3_wide",      32'(widePulses), 32'd0);
      checkOutput("p3_spacing_ge5", 32'(minSpacing >= 5), 32'd1);

      // Realign from LOCKED: aligned drops next clock, word now already aligned
      pulseStart = pulseCount;
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rl_aligned",  32'(aligned),  32'd0);
      checkOutput("rl_slip_cnt", 32'(slip_cnt), 32'd0);
      waitForDone("rl_done", 100);
      checkOutput("rl_relock",   32'(aligned), 32'd1);
      checkOutput("rl_pulses",   32'(pulseCount - pulseStart), 32'd0);

      // SelectIO reset mid-CHECK: no lock while held
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(3);
      releaseIo(8'hF0);
      tick(12);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(3);
      checkOutput("ck_io_rst_aligned",  32'(aligned),  32'd0);
      checkOutput("ck_io_rst_slip_cnt", 32'(slip_cnt), 32'd0);
      tick(20);
      checkOutput("ck_io_rst_held",   32'(aligned), 32'd0);
      checkOutput("ck_io_rst_pulses", 32'(pulseCount - pulseStart), 32'd0);

      // One mismatch after 10 matches: one slip, then 16 fresh matches
      $display("[TB] mismatch restart");
      releaseIo(8'hF0);
      tick(17);
      checkOutput("mm_before", 32'(aligned), 32'd0);
      baseWord = 8'h78;
      tick(1);
      tick(20);
      checkOutput("mm_no_early", 32'(aligned), 32'd0);
      tick(1);
      checkOutput("mm_lock",     32'(aligned),  32'd1);
      checkOutput("mm_pulses",   32'(pulseCount - pulseStart), 32'd1);
      checkOutput("mm_slip_cnt", 32'(slip_cnt), 32'd1);

      // Never-matching data: seven slips then failure
      $display("[TB] no-lock failure");
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(3);
      randomMode = 1'b1;
      releaseIo(8'hF0);
      waitForDone("rnd_done", 400);
      checkOutput("rnd_align_err", 32'(align_err), 32'd1);
      checkOutput("rnd_aligned",   32'(aligned),   32'd0);
      checkOutput("rnd_slip_cnt",  32'(slip_cnt),  32'd7);
      checkOutput("rnd_pulses",    32'(pulseCount - pulseStart), 32'd7);

      // Realign from FAIL, with a stray realign during SETTLE that must be ignored
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rf_align_err", 32'(align_err), 32'd0);
      checkOutput("rf_slip_cnt",  32'(slip_cnt),  32'd0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(2);
      checkOutput("rf_no_slip_yet", 32'(bitslip), 32'd0);
      tick(1);
      checkOutput("rf_first_slip", 32'(bitslip), 32'd1);
      tick(1);
      checkOutput("rf_slip_cnt1", 32'(slip_cnt), 32'd1);

      // Synchronous reset while in SETTLE: all outputs low next clock
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(1);
      checkOutput("sr_bitslip",   32'(bitslip),   32'd0);
      checkOutput("sr_aligned",   32'(aligned),   32'd0);
      checkOutput("sr_align_err", 32'(align_err), 32'd0);
      checkOutput("sr_slip_cnt",  32'(slip_cnt),  32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      randomMode = 1'b0;
      tick(2);

      checkOutput("all_wide",       32'(widePulses), 32'd0);
      checkOutput("all_spacing_ge5", 32'(minSpacing >= 5), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
